bcd_to_binary_signed: RTL and testbench
=======================================

# bcd_to_binary_signed

Sequential reverse double-dabble converter. It turns a 10-digit packed BCD magnitude plus a sign flag into a 32-bit two's-complement or unsigned binary value. It sits in the UART AHB-L command path and converts decimal numbers typed by the host into register/address values. It also reports range and digit errors.

## Interface
Parameters: none (widths fixed: 10 BCD digits, 32-bit result).
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- stb_i  in  1  start request; sampled only in IDLE
- sign_en  in  1  1 = signed result range, 0 = unsigned
- sign_neg_i  in  1  1 = value is negative; used only when sign_en=1
- bcd_i  in  40  packed BCD, digit 0 in [3:0], digit 9 in [39:36]
- bin_o  out  32  converted result, registered
- done_o  out  1  one-cycle pulse: bin_o/err_o are valid and updated
- busy_o  out  1  conversion in progress (state != IDLE)
- err_o  out  1  last conversion had an invalid digit or was out of range; registered, valid with done_o

## Operation
- States: IDLE, CONV, FIN.
- IDLE, stb_i=1:
  - Capture bcd_i into r_bcd[39:0] and clear r_bin[33:0].
  - Capture sign_en and sign_neg_i.
  - Set r_bad = 1 if any nibble > 9.
  - Clear r_cnt. Go to CONV.
- CONV, each cycle:
  - r_bin <= {r_bcd[0], r_bin[33:1]}.
  - r_bcd shifts right by 1. Then every shifted digit >= 8 has 3 subtracted.
  - r_cnt increments.
  - After 34 shifts (r_cnt = 33 on the last one), go to FIN.
- Magnitude: mag = r_bin[33:0]; maximum is 9 999 999 999, which is < 2^34.
- FIN, range check:
  - unsigned (sign_en=0): ok if mag <= 4294967295.
  - signed positive: ok if mag <= 2147483647.
  - signed negative: ok if mag <= 2147483648.
- FIN, result:
  - r_bad=1: bin_o=0, err_o=1.
  - ovf=1: err_o=1; bin_o per Configuration.
  - otherwise: bin_o = neg ? -mag[31:0] : mag[31:0]; err_o=0.
  - Negative zero yields 0 with err_o=0.
- FIN also pulses done_o and returns to IDLE.
- stb_i while busy_o=1 is ignored (no queueing). Input changes during conversion have no effect.
- bin_o and err_o hold their values until the next FIN.

## Timing
- Reset: bin_o=0, done_o=0, busy_o=0, err_o=0. State IDLE; all internal registers 0.
- Edge E0 samples stb_i=1. E1..E34 perform the shifts. E35 (FIN) updates bin_o/err_o and sets done_o=1.
- done_o is high for exactly the cycle after E35 and clears at E36.
- busy_o is high from E0 through E35. State is IDLE after E35, so the earliest next accepted stb_i is at E36.
- Throughput: one conversion per 36 cycles.
- resetn asserted at any point (including mid-CONV or during the done_o cycle): immediate return to reset values. No done_o is produced for the aborted conversion.

## Configuration
- BCD2BIN_SAT_EN defined: on overflow, bin_o saturates.
  - unsigned: 32'hFFFFFFFF.
  - signed positive: 32'h7FFFFFFF.
  - signed negative: 32'h80000000.
  - err_o=1.
- BCD2BIN_SAT_EN undefined: on overflow, bin_o = neg ? -mag[31:0] : mag[31:0] (wrapped); err_o=1.
- Invalid-digit behaviour (bin_o=0, err_o=1) is the same in both builds.

## Test plan
- Unsigned max: sign_en=0, bcd_i=40'h4294967295, pulse stb_i. Require bin_o=32'hFFFFFFFF, err_o=0, done_o on E35, busy_o low after E35.
- Signed minimum: sign_en=1, sign_neg_i=1, bcd_i=40'h2147483648. Require bin_o=32'h80000000, err_o=0.
- Signed overflow: sign_en=1, sign_neg_i=0, bcd_i=40'h2147483648. Require err_o=1; bin_o=32'h7FFFFFFF with BCD2BIN_SAT_EN, 32'h80000000 without.
- Invalid digit: bcd_i=40'h00000000A1. Require bin_o=0, err_o=1, done_o still pulses at E35.
- Negative zero plus ignored strobe: sign_en=1, sign_neg_i=1, bcd_i=0, second stb_i at E10. Require bin_o=0, err_o=0, exactly one done_o.
- Reset mid-conversion: assert resetn low at E10. Require all outputs 0 and no done_o. Then run bcd_i=40'h0000012345, sign_en=0, and require bin_o=32'h00003039.

Source files
------------

// File: rtl/bcd_to_binary_signed.sv
// Sequential reverse double-dabble: 10-digit packed BCD plus sign to 32-bit binary, with range/digit error flag.
// Define BCD2BIN_SAT_EN to saturate bin_o on overflow; otherwise the overflowed result wraps.
module bcd_to_binary_signed (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stb_i,
  input  logic        sign_en,
  input  logic        sign_neg_i,
  input  logic [39:0] bcd_i,
  output logic [31:0] bin_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

  state_t      state, state_nxt;
  logic [39:0] r_bcd, bcd_shift;
  logic [33:0] r_bin;
  logic [5:0]  r_cnt;
  logic        r_signed, r_neg, r_bad;
  logic        any_bad, neg, ovf;
  logic [31:0] wrap_val, ovf_val;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < 10; i++)
      if (bcd_i[4*i +: 4] > 4'd9) any_bad = 1'b1;
  end

  // Halving a digit that received the upper digit's low bit adds 8 where 5 is meant.
  always_comb begin
    bcd_shift = {1'b0, r_bcd[39:1]};
    for (int i = 0; i < 10; i++)
      if (bcd_shift[4*i +: 4] >= 4'd8) bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
  end

  assign neg      = r_signed & r_neg;
  assign wrap_val = neg ? (32'd0 - r_bin[31:0]) : r_bin[31:0];

  always_comb begin
    if (!r_signed)  ovf = (r_bin[33:32] != 2'b00);
    else if (neg)   ovf = (r_bin > 34'd2147483648);
    else            ovf = (r_bin > 34'd2147483647);
  end

`ifdef BCD2BIN_SAT_EN
  always_comb begin
    if (!r_signed)  ovf_val = 32'hFFFF_FFFF;
    else if (neg)   ovf_val = 32'h8000_0000;
    else            ovf_val = 32'h7FFF_FFFF;
  end
`else
  assign ovf_val = wrap_val;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (stb_i) state_nxt = CONV;
      CONV:    if (r_cnt == 6'd33) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
      r_bad    <= 1'b0;
      bin_o    <= '0;
      err_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (stb_i) begin
            r_bcd    <= bcd_i;
            r_bin    <= '0;
            r_signed <= sign_en;
            r_neg    <= sign_neg_i;
            r_bad    <= any_bad;
            r_cnt    <= '0;
          end
        end
        CONV: begin
          r_bin <= {r_bcd[0], r_bin[33:1]};
          r_bcd <= bcd_shift;
          r_cnt <= r_cnt + 6'd1;
        end
        FIN: begin
          done_o <= 1'b1;
          if (r_bad) begin
            bin_o <= '0;
            err_o <= 1'b1;
          end else if (ovf) begin
            bin_o <= ovf_val;
            err_o <= 1'b1;
          end else begin
            bin_o <= wrap_val;
            err_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_signed.sv
// Scoreboard bench for bcd_to_binary_signed: stimulus pushes expected results, a monitor checks each done_o pulse.
module tb_bcd_to_binary_signed;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stb_i = 1'b0;
  logic        sign_en = 1'b0;
  logic        sign_neg_i = 1'b0;
  logic [39:0] bcd_i = '0;
  logic [31:0] bin_o;
  logic        done_o, busy_o, err_o;

  typedef struct {
    logic [31:0] bin;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   t0 = 0;

`ifdef BCD2BIN_SAT_EN
  localparam logic [31:0] OVF_US_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_US_4G  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_SP     = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_SN     = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_US_MAX = 32'h540B_E3FF;
  localparam logic [31:0] OVF_US_4G  = 32'h0000_0000;
  localparam logic [31:0] OVF_SP     = 32'h8000_0000;
  localparam logic [31:0] OVF_SN     = 32'h7FFF_FFFF;
`endif

  bcd_to_binary_signed dut (
    .clk        (clk),
    .resetn     (resetn),
    .stb_i      (stb_i),
    .sign_en    (sign_en),
    .sign_neg_i (sign_neg_i),
    .bcd_i      (bcd_i),
    .bin_o      (bin_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && done_o) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("bin_o", {32'd0, bin_o}, {32'd0, e.bin});
        chk("err_o", {63'd0, err_o}, {63'd0, e.err});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_after_fin", {63'd0, busy_o}, 64'd0);
      end
    end
  end

  task automatic start(input logic se, input logic sn, input logic [39:0] bcd,
                       input logic [31:0] eb, input logic ee, input bit push);
    exp_t e;
    @(negedge clk);
    sign_en    = se;
    sign_neg_i = sn;
    bcd_i      = bcd;
    stb_i      = 1'b1;
    t0         = cyc;
    if (push) begin
      e.bin = eb;
      e.err = ee;
      e.cyc = t0 + 36;
      q.push_back(e);
    end
    @(negedge clk);
    stb_i      = 1'b0;
    bcd_i      = 40'h98_7654_3210;
    sign_en    = ~se;
    sign_neg_i = ~sn;
    chk("busy_after_e0", {63'd0, busy_o}, 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 64'd1, 64'd0);
      q.delete();
    end
  endtask

  task automatic run(input logic se, input logic sn, input logic [39:0] bcd,
                     input logic [31:0] eb, input logic ee);
    start(se, sn, bcd, eb, ee, 1'b1);
    wait_done();
  endtask

  initial begin
    int dn0;
    #12;
    chk("rst_bin", {32'd0, bin_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run(1'b0, 1'b0, 40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done_o}, 64'd0);
    run(1'b1, 1'b1, 40'h21_4748_3648, 32'h8000_0000, 1'b0);
    run(1'b1, 1'b0, 40'h21_4748_3647, 32'h7FFF_FFFF, 1'b0);
    run(1'b1, 1'b1, 40'h00_0000_0001, 32'hFFFF_FFFF, 1'b0);
    run(1'b0, 1'b0, 40'h99_9999_9999, OVF_US_MAX, 1'b1);
    run(1'b0, 1'b0, 40'h42_9496_7296, OVF_US_4G, 1'b1);
    run(1'b1, 1'b1, 40'h21_4748_3649, OVF_SN, 1'b1);
    run(1'b0, 1'b0, 40'h00_0000_00A1, 32'h0000_0000, 1'b1);
    run(1'b1, 1'b0, 40'hF0_0000_0000, 32'h0000_0000, 1'b1);
    run(1'b1, 1'b0, 40'h21_4748_3648, OVF_SP, 1'b1);

    // reset in the middle of a conversion, following a result with err_o=1
    start(1'b0, 1'b0, 40'h00_0001_2345, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    dn0 = n_done;
    resetn = 1'b0;
    #1;
    chk("abort_bin", {32'd0, bin_o}, 64'd0);
    chk("abort_done", {63'd0, done_o}, 64'd0);
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_err", {63'd0, err_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(n_done - dn0), 64'd0);
    run(1'b0, 1'b0, 40'h00_0001_2345, 32'h0000_3039, 1'b0);

    // negative zero with a second strobe while busy
    dn0 = n_done;
    start(1'b1, 1'b1, 40'h00_0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    stb_i = 1'b1;
    @(negedge clk);
    stb_i = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    chk("single_done", 64'(n_done - dn0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
